// File: rtl/lockstep_diverge_monitor.sv
// Two-copy lockstep monitor: sequences reset for both model copies, then compares
// valid-qualified observation channels over a cycle window and records divergence.
module lockstep_diverge_monitor #(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 32,
    parameter int CNT_W        = 8,
    parameter int RESET_CYCLES = 2,
    parameter int CHECK_START  = 4,
    parameter int CHECK_END    = 14,
    parameter int MODE         = 1,
    localparam int FCW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_CH-1:0]      ch_mask,
    input  logic [NUM_CH-1:0]      ch_valid_a,
    input  logic [NUM_CH-1:0]      ch_valid_b,
    input  logic [NUM_CH*CH_W-1:0] ch_data_a,
    input  logic [NUM_CH*CH_W-1:0] ch_data_b,
    output logic                   copy_reset,
    output logic                   init_window,
    output logic                   check_en,
    output logic [CNT_W-1:0]       cycle,
    output logic [NUM_CH-1:0]      div_sticky,
    output logic                   diverge,
    output logic [FCW-1:0]         first_ch,
    output logic [CNT_W-1:0]       first_cycle,
    output logic                   done,
    output logic                   pass
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_C  = CNT_W'(CHECK_START);
    localparam logic [CNT_W-1:0] END_C    = CNT_W'(CHECK_END);

    typedef enum logic [1:0] {IDLE, RESET_SEQ, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cycle_nxt;
    logic [NUM_CH-1:0]  mism;
    logic [NUM_CH-1:0]  sticky_nxt;
    logic [FCW-1:0]     low_idx;
    logic [FCW-1:0]     fch_nxt;
    logic [CNT_W-1:0]   fcy_nxt;

    assign init_window = (state == RESET_SEQ) && (cycle == '0);

    always_comb begin
        check_en = 1'b0;
        if (state == RUN) begin
            if (MODE != 0) begin
                check_en = (cycle >= START_C) && (cycle <= END_C);
            end else begin
                check_en = (cycle == END_C);
            end
        end
    end

    // A channel diverges on a valid disagreement, or on data disagreement when both are valid.
    always_comb begin
        mism = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mism[i] = ch_mask[i] &&
                      ((ch_valid_a[i] ^ ch_valid_b[i]) ||
                       (ch_valid_a[i] && ch_valid_b[i] &&
                        (ch_data_a[i*CH_W +: CH_W] != ch_data_b[i*CH_W +: CH_W])));
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mism[i]) begin
                low_idx = FCW'(i);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cycle_nxt  = cycle;
        sticky_nxt = div_sticky;
        fch_nxt    = first_ch;
        fcy_nxt    = first_cycle;

        if (check_en && (|mism)) begin
            sticky_nxt = div_sticky | mism;
            if (!diverge) begin
                fch_nxt = low_idx;
                fcy_nxt = cycle;
            end
        end

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt  = RESET_SEQ;
                    cycle_nxt  = '0;
                    sticky_nxt = '0;
                    fch_nxt    = '0;
                    fcy_nxt    = '0;
                end
            end
            RESET_SEQ: begin
                cycle_nxt = cycle + 1'b1;
                if (cycle == RST_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // cycle holds at CHECK_END on the way into DONE so it can never wrap
                if (cycle == END_C) begin
                    state_nxt = DONE;
                end else begin
                    cycle_nxt = cycle + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cycle       <= '0;
            div_sticky  <= '0;
            first_ch    <= '0;
            first_cycle <= '0;
            copy_reset  <= 1'b1;
            diverge     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cycle       <= cycle_nxt;
            div_sticky  <= sticky_nxt;
            first_ch    <= fch_nxt;
            first_cycle <= fcy_nxt;
            copy_reset  <= (state_nxt != RUN);
            diverge     <= |sticky_nxt;
            done        <= (state_nxt == DONE);
            pass        <= (state_nxt == DONE) && !(|sticky_nxt);
        end
    end

endmodule
